// File: rtl/vx_csr_req_arb.sv
// vx_csr_req_arb
//   Round-robin arbiter sharing the CSR unit request port among NUM_REQS
//   issue-side requesters. The winning request is captured into a 2-entry
//   elastic buffer whose head drives the CSR unit directly from registers.
//   A saturating counter reports cycles in which a request went ungranted.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   req_valid    per-requester request valid               [NUM_REQS]
//   req_data     per-requester payload, slot i at [i*DATAW +: DATAW]
//   req_ready    per-requester accept, one-hot or zero     [NUM_REQS]
//   out_valid    request valid toward the CSR unit
//   out_data     payload of the head entry                 [DATAW]
//   out_idx      requester index of the head entry         [IDXW]
//   out_ready    CSR unit accept
//   perf_stalls  cycles with any request valid but no grant (saturating)
module vx_csr_req_arb #(
   parameter int NUM_REQS = 4,
   parameter int DATAW    = 256,
   parameter int IDXW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQS-1:0]       req_valid,
   input  logic [NUM_REQS*DATAW-1:0] req_data,
   output logic [NUM_REQS-1:0]       req_ready,
   output logic                      out_valid,
   output logic [DATAW-1:0]          out_data,
   output logic [IDXW-1:0]           out_idx,
   input  logic                      out_ready,
   output logic [31:0]               perf_stalls
);

   localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

   logic [IDXW-1:0]  rr_ptr;
   logic [IDXW-1:0]  grant_idx;
   logic             found;
   logic             can_push;
   logic             push;
   logic             pop;
   logic [DATAW-1:0] grant_data;

   // Buffer entries: _p0 is the head (drives the outputs), _p1 the tail.
   // vld_p1 implies vld_p0, so {vld_p1, vld_p0} encodes the count.
   logic             vld_p0, vld_p1;
   logic [DATAW-1:0] data_p0, data_p1;
   logic [IDXW-1:0]  idx_p0, idx_p1;

   // ---- Arbitration stage: scan from rr_ptr upward, wrapping ----
   always_comb begin
      int scan;
      scan      = 0;
      found     = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_REQS; k++) begin
         scan = int'(rr_ptr) + k;
         if (scan >= NUM_REQS) scan = scan - NUM_REQS;
         if (!found && req_valid[scan[IDXW-1:0]]) begin
            found     = 1'b1;
            grant_idx = scan[IDXW-1:0];
         end
      end
   end

   // Space is judged on the registered occupancy only, so req_ready never
   // depends combinationally on out_ready.
   assign can_push   = !vld_p1;
   assign push       = found && can_push && !reset;
   assign pop        = vld_p0 && out_ready;
   assign grant_data = req_data[grant_idx*DATAW +: DATAW];

   always_comb begin
      req_ready = '0;
      if (push) req_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (push) begin
         if (grant_idx == IDXW'(NUM_REQS - 1)) rr_ptr <= '0;
         else                                  rr_ptr <= grant_idx + 1'b1;
      end
   end

   // ---- Buffer stage: 2-entry FIFO, head always in _p0 ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         data_p0 <= '0;
         data_p1 <= '0;
         idx_p0  <= '0;
         idx_p1  <= '0;
      end else if (vld_p1) begin
         // full: no push possible, a pop shifts the tail into the head
         if (pop) begin
            data_p0 <= data_p1;
            idx_p0  <= idx_p1;
            vld_p1  <= 1'b0;
         end
      end else if (vld_p0) begin
         if (push && pop) begin
            data_p0 <= grant_data;
            idx_p0  <= grant_idx;
         end else if (push) begin
            data_p1 <= grant_data;
            idx_p1  <= grant_idx;
            vld_p1  <= 1'b1;
         end else if (pop) begin
            vld_p0  <= 1'b0;
         end
      end else if (push) begin
         data_p0 <= grant_data;
         idx_p0  <= grant_idx;
         vld_p0  <= 1'b1;
      end
   end

   assign out_valid = vld_p0;
   assign out_data  = data_p0;
   assign out_idx   = idx_p0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stalls <= '0;
      end else if ((|req_valid) && !push && (perf_stalls != PERF_MAX)) begin
         perf_stalls <= perf_stalls + 32'd1;
      end
   end

endmodule

// File: tb/tb_vx_csr_req_arb.sv
module tb_vx_csr_req_arb;

   localparam int N  = 4;
   localparam int DW = 256;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [IW-1:0]   out_idx;
   logic            out_ready;
   logic [31:0]     perf_stalls;

   vx_csr_req_arb #(.NUM_REQS(N), .DATAW(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_idx    (out_idx),
      .out_ready  (out_ready),
      .perf_stalls(perf_stalls)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: requesters hold a pending request until accepted,
   // the buffer is a plain queue, the pointer is an integer.
   logic [N-1:0]  pend;
   logic [DW-1:0] pdat [N];
   logic [DW-1:0] q_data [$];
   int            q_idx [$];
   int            m_ptr;
   logic [31:0]   m_perf;

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] r;
      for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic model_clear();
      pend = '0;
      q_data.delete();
      q_idx.delete();
      m_ptr  = 0;
      m_perf = '0;
   endtask

   task automatic drive();
      req_valid = pend;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pdat[i];
   endtask

   // One clock cycle: requesters allowed by 'allow' raise a request with
   // probability 'prob' percent; outputs are checked against the model
   // mid-cycle; g returns the granted index or -1.
   task automatic cycle(input logic [N-1:0] allow, input int prob, input logic ordy, output int g);
      logic          push, pop, any;
      logic [N-1:0]  exp_rdy;
      @(negedge clk);
      for (int i = 0; i < N; i++)
         if (!pend[i] && allow[i] && ($urandom_range(99) < prob)) begin
            pend[i] = 1'b1;
            pdat[i] = rand_data();
         end
      drive();
      out_ready = ordy;
      #1;
      g = -1;
      for (int k = 0; k < N; k++)
         if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      push    = (g >= 0) && (q_data.size() < 2);
      exp_rdy = push ? (N'(1) << g) : '0;
      any     = |pend;
      check("req_ready", DW'(req_ready), DW'(exp_rdy));
      check("out_valid", DW'(out_valid), DW'(q_data.size() != 0));
      if (q_data.size() != 0) begin
         check("out_data", out_data, q_data[0]);
         check("out_idx", DW'(out_idx), DW'(q_idx[0]));
      end
      check("perf_stalls", DW'(perf_stalls), DW'(m_perf));
      @(posedge clk);
      pop = (q_data.size() != 0) && ordy;
      if (pop) begin
         void'(q_data.pop_front());
         void'(q_idx.pop_front());
      end
      if (push) begin
         q_data.push_back(pdat[g]);
         q_idx.push_back(g);
         pend[g] = 1'b0;
         m_ptr   = (g + 1) % N;
      end else begin
         g = -1;
      end
      if (any && !push && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      req_valid = '1;
      out_ready = 1'b1;
      #1;
      check("rst_req_ready", DW'(req_ready), '0);
      @(posedge clk);
      #1;
      check("rst_out_valid", DW'(out_valid), '0);
      check("rst_out_data", out_data, '0);
      check("rst_out_idx", DW'(out_idx), '0);
      check("rst_perf", DW'(perf_stalls), '0);
      model_clear();
      @(negedge clk);
      drive();
      reset = 1'b0;
   endtask

   initial begin
      int g;
      for (int i = 0; i < N; i++) pdat[i] = '0;
      model_clear();
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      out_ready = 1'b0;
      do_reset();

      // single request from requester 2
      cycle(4'b0100, 100, 1'b1, g);
      check("single_grant", DW'(g), DW'(2));
      cycle(4'b0000, 0, 1'b1, g);
      cycle(4'b1111, 100, 1'b1, g);
      check("ptr_after_single", DW'(g), DW'(3));

      // fairness with everybody continuously valid
      do_reset();
      for (int c = 0; c < 8; c++) begin
         cycle(4'b1111, 100, 1'b1, g);
         check("rr_order", DW'(g), DW'(c % 4));
      end
      check("no_stalls", DW'(perf_stalls), '0);

      // backpressure: two pushes then blocked; then drain
      do_reset();
      for (int c = 0; c < 5; c++) begin
         cycle(4'b1111, 100, 1'b0, g);
         check("bp_grant", DW'(g), (c < 2) ? DW'(c) : '1);
      end
      for (int c = 0; c < 4; c++) cycle(4'b1111, 100, 1'b1, g);

      // back-to-back single requester 3
      for (int c = 0; c < 8; c++) begin
         cycle(4'b1000, 100, 1'b1, g);
         if (c >= 3) check("b2b_grant", DW'(g), DW'(3));
      end

      // randomized traffic
      for (int c = 0; c < 400; c++)
         cycle(N'($urandom), $urandom_range(100), 1'($urandom_range(3) != 0), g);

      // asynchronous reset with a full buffer
      cycle(4'b1111, 100, 1'b0, g);
      cycle(4'b1111, 100, 1'b0, g);
      check("full_before_rst", DW'(out_valid), DW'(1));
      #2;
      reset = 1'b1;
      #1;
      check("async_out_valid", DW'(out_valid), '0);
      check("async_req_ready", DW'(req_ready), '0);
      model_clear();
      @(negedge clk);
      drive();
      reset = 1'b0;
      cycle(4'b1111, 100, 1'b1, g);
      check("grant_after_rst", DW'(g), DW'(0));

      // counter saturation
      do_reset();
      cycle(4'b1111, 100, 1'b0, g);
      cycle(4'b1111, 100, 1'b0, g);
      #2;
      force dut.perf_stalls = 32'hFFFF_FFFE;
      #1;
      release dut.perf_stalls;
      m_perf = 32'hFFFF_FFFE;
      for (int c = 0; c < 4; c++) cycle(4'b1111, 100, 1'b0, g);
      check("perf_saturated", DW'(perf_stalls), DW'(32'hFFFF_FFFF));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
